// File: rtl/seg2hex.sv
// Recovers a 0..15 value from a two-digit (tens/units) 7-segment scan with per-digit debounce.
// Optional build macro SEG2HEX_STICKY_ERR_EN holds pat_err/range_err until rst or the next hex_valid.
module seg2hex #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic [1:0] dig_sel,
  output logic [3:0] hex_out,
  output logic       hex_valid,
  output logic       pat_err,
  output logic       range_err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SUM_W = 7;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 2);

  typedef enum logic [1:0] {EMPTY, HAVE_TENS, HAVE_UNITS, EMIT} state_e;

  state_e           state_q, state_d;
  logic [6:0]       seg_q;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       tens_q, tens_d, units_q, units_d;
  logic [3:0]       hex_q, hex_d;
  logic             valid_q, valid_d, pat_q, pat_d, range_q, range_d;

  logic             match, capture, glyph_ok, is_tens, good_cap, pat_now, range_now;
  logic [3:0]       glyph_val;
  logic [SUM_W-1:0] sum;

  // Active-low glyph decode; blank and any other pattern are illegal.
  always_comb begin
    glyph_ok  = 1'b1;
    glyph_val = 4'd0;
    case (seg_in)
      7'b0000001: glyph_val = 4'd0;
      7'b1001111: glyph_val = 4'd1;
      7'b0010010: glyph_val = 4'd2;
      7'b0000110: glyph_val = 4'd3;
      7'b1001100: glyph_val = 4'd4;
      7'b0100100: glyph_val = 4'd5;
      7'b0100000: glyph_val = 4'd6;
      7'b0001111: glyph_val = 4'd7;
      7'b0000000: glyph_val = 4'd8;
      7'b0000100: glyph_val = 4'd9;
      default:    glyph_ok  = 1'b0;
    endcase
  end

  // Stability counter: the incoming sample is compared with the held one, so the
  // capture lands on the edge that takes the STABLE_CYCLES-th identical sample.
  always_comb begin
    match   = ({dig_sel, seg_in} == {sel_q, seg_q}) && (dig_sel == 2'b10 || dig_sel == 2'b01);
    cnt_d   = '0;
    capture = 1'b0;
    if (match) begin
      cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
      capture = (cnt_q == CNT_CAP);
    end
    is_tens  = dig_sel[1];
    good_cap = capture && glyph_ok;
    pat_now  = capture && !glyph_ok;
  end

  // Frame assembly; the sum is formed at full width before the range check.
  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    units_d   = units_q;
    hex_d     = hex_q;
    valid_d   = 1'b0;
    range_now = 1'b0;
    sum       = SUM_W'(tens_q) * SUM_W'(10) + SUM_W'(units_q);
    case (state_q)
      EMPTY, EMIT: begin
        if (state_q == EMIT) begin
          if (sum <= SUM_W'(15)) begin
            hex_d   = sum[3:0];
            valid_d = 1'b1;
          end else begin
            range_now = 1'b1;
          end
          state_d = EMPTY;
        end
        if (good_cap) begin
          if (is_tens) begin
            tens_d  = glyph_val;
            state_d = HAVE_TENS;
          end else begin
            units_d = glyph_val;
            state_d = HAVE_UNITS;
          end
        end
      end
      HAVE_TENS: begin
        if (good_cap) begin
          if (is_tens) begin
            tens_d = glyph_val;
          end else begin
            units_d = glyph_val;
            state_d = EMIT;
          end
        end
      end
      HAVE_UNITS: begin
        if (good_cap) begin
          if (is_tens) begin
            tens_d  = glyph_val;
            state_d = EMIT;
          end else begin
            units_d = glyph_val;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
`ifdef SEG2HEX_STICKY_ERR_EN
    pat_d   = pat_now   || (pat_q   && !valid_d);
    range_d = range_now || (range_q && !valid_d);
`else
    pat_d   = pat_now;
    range_d = range_now;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      seg_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      tens_q  <= '0;
      units_q <= '0;
      hex_q   <= '0;
      valid_q <= 1'b0;
      pat_q   <= 1'b0;
      range_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_in;
      sel_q   <= dig_sel;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      hex_q   <= hex_d;
      valid_q <= valid_d;
      pat_q   <= pat_d;
      range_q <= range_d;
    end
  end

  assign hex_out   = hex_q;
  assign hex_valid = valid_q;
  assign pat_err   = pat_q;
  assign range_err = range_q;

endmodule
